// File: rtl/framing_arbiter_if.sv
// Bus between the framing arbiter, the two per-source byte FIFOs and the framer.
// The arbiter attaches through the slave modport; the environment drives the master side.
interface framing_arbiter_if #(
  parameter int LEN_W = 7
);
  logic [1:0]       req;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [7:0]       data0;
  logic [7:0]       data1;
  logic [1:0]       rd_en;
  logic [1:0]       grant;
  logic [1:0]       done;
  logic             err;
  logic             busy;
  logic [7:0]       fr_din;
  logic             fr_indicator;
  logic             fr_next_indicator;

  modport slave (
    input  req, len0, len1, data0, data1, fr_next_indicator,
    output rd_en, grant, done, err, busy, fr_din, fr_indicator
  );

  modport master (
    output req, len0, len1, data0, data1, fr_next_indicator,
    input  rd_en, grant, done, err, busy, fr_din, fr_indicator
  );
endinterface

// File: rtl/framing_arbiter.sv
// Round-robin owner of a shared framing/CRC framer for two frame sources.
// Issues the framer start strobe, counts out the preamble, streams the granted
// source's bytes with a last-byte strobe, then waits for the framer's end strobe
// (with a watchdog) before reporting done for that source.
module framing_arbiter #(
  parameter int SHR_CYCLES     = 80,
  parameter int FCS_CYCLES     = 16,
  parameter int TIMEOUT_MARGIN = 4,
  parameter int LEN_W          = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  framing_arbiter_if.slave   bus_if
);

  // Counter is wide enough for a full frame length as well as the fixed phases.
  localparam int CNT_W = LEN_W + 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ZLEN  = 3'd1;  // zero-length frame: report error, no framer activity
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_SHR   = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_FCS   = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] SHR_LAST = CNT_W'(SHR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(FCS_CYCLES + TIMEOUT_MARGIN - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             g_q, g_d;        // index of the granted source
  logic             rr_q, rr_d;      // index of the source served last
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       rd_en_q, rd_en_d;
  logic [1:0]       done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             ind_q, ind_d;

  logic             win_s;
  logic [LEN_W-1:0] win_len_s;
  logic [7:0]       din_s;

  function automatic logic [1:0] onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

  // Pick the winner: a lone requester wins, on contention the one not served last.
  always_comb begin
    if (bus_if.req == 2'b11) begin
      win_s = ~rr_q;
    end else begin
      win_s = bus_if.req[1];
    end
    win_len_s = win_s ? bus_if.len1 : bus_if.len0;
  end

  // Frame sequencer: next state, counter, latched grant/length and done/err pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    g_d     = g_q;
    rr_d    = rr_q;
    done_d  = 2'b00;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // No new grant in the cycle a done pulse is out.
        if ((done_q == 2'b00) && (bus_if.req != 2'b00)) begin
          g_d   = win_s;
          len_d = {8'd0, win_len_s};
          cnt_d = CNT_ZERO;
          if (win_len_s == {LEN_W{1'b0}}) begin
            state_d = S_ZLEN;
          end else begin
            state_d = S_START;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ZLEN: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
        done_d  = onehot(g_q);
        err_d   = 1'b1;
        rr_d    = g_q;
      end
      S_START: begin
        state_d = S_SHR;
        cnt_d   = CNT_ZERO;
      end
      S_SHR: begin
        if (cnt_q == SHR_LAST) begin
          state_d = S_DATA;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == (len_q - CNT_ONE)) begin
          state_d = S_FCS;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_FCS: begin
        // The framer end strobe is only honoured here; the watchdog covers a lost strobe.
        if (bus_if.fr_next_indicator) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
          done_d  = onehot(g_q);
          rr_d    = g_q;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
          done_d  = onehot(g_q);
          err_d   = 1'b1;
          rr_d    = g_q;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the next state so grant/rd_en/busy/indicator come straight from flops.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    if (state_d != S_IDLE) begin
      grant_d = onehot(g_d);
    end else begin
      grant_d = 2'b00;
    end
    if (state_d == S_DATA) begin
      rd_en_d = onehot(g_d);
    end else begin
      rd_en_d = 2'b00;
    end
    if (state_d == S_START) begin
      ind_d = 1'b1;
    end else if ((state_d == S_DATA) && (cnt_d == (len_d - CNT_ONE))) begin
      ind_d = 1'b1;
    end else begin
      ind_d = 1'b0;
    end
  end

  // The byte must be the FIFO head of the very cycle rd_en pops it, so it is muxed live.
  always_comb begin
    if (state_q == S_DATA) begin
      din_s = g_q ? bus_if.data1 : bus_if.data0;
    end else begin
      din_s = 8'h00;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      len_q   <= CNT_ZERO;
      g_q     <= 1'b0;
      rr_q    <= 1'b1;
      grant_q <= 2'b00;
      rd_en_q <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ind_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ind_q   <= ind_d;
    end
  end

  assign bus_if.grant        = grant_q;
  assign bus_if.rd_en        = rd_en_q;
  assign bus_if.done         = done_q;
  assign bus_if.err          = err_q;
  assign bus_if.busy         = busy_q;
  assign bus_if.fr_indicator = ind_q;
  assign bus_if.fr_din       = din_s;

endmodule

// File: tb/tb_framing_arbiter.sv
// Randomized bench for framing_arbiter. Two requesters with show-ahead byte
// FIFOs and a framer stand-in are driven each cycle; a frame-timeline model
// predicts every output cycle by cycle from the arbitration rules and the
// fixed phase lengths (start, preamble, data, FCS, done).
module tb_framing_arbiter;
  localparam int LEN_W  = 7;
  localparam int SHR    = 80;
  localparam int FCS    = 16;
  localparam int MARGIN = 4;
  localparam int NFRAMES = 40;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  framing_arbiter_if #(.LEN_W(LEN_W)) bus_if ();

  framing_arbiter #(
    .SHR_CYCLES(SHR), .FCS_CYCLES(FCS), .TIMEOUT_MARGIN(MARGIN), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus_if(bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Requesters
  bit pend[2];
  int plen[2];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit pop0, pop1;

  // Frame-timeline model
  bit act = 1'b0;
  int s, g, L, j, dk;
  bit err_m;
  logic [7:0] fb[$];
  int done_cyc = -10;
  int last = 1;
  int frames = 0;
  int resets = 0;
  bit directed = 1'b1;
  bit rst_mid = 1'b0;
  bit post_rst = 1'b0;

  function automatic int rndlen();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return 0;
    else if (r == 1) return 127;
    else if (r == 2) return int'($urandom_range(2, 127));
    else return int'($urandom_range(1, 6));
  endfunction

  task automatic mkframe(input int i, input int len);
    pend[i] = 1'b1;
    plen[i] = len;
    for (int b = 0; b < len; b++) begin
      if (i == 0) q0.push_back(8'($urandom));
      else        q1.push_back(8'($urandom));
    end
  endtask

  initial begin
    logic [1:0] eg, er, ed, oh;
    logic ee, eb, ei, nxt;
    logic [7:0] edin;
    bit rst_now;
    int k, w, fcs0, r;

    pend[0] = 1'b0; pend[1] = 1'b0;
    pop0 = 1'b0; pop1 = 1'b0;
    bus_if.req = 2'b00; bus_if.len0 = '0; bus_if.len1 = '0;
    bus_if.data0 = 8'h00; bus_if.data1 = 8'h00; bus_if.fr_next_indicator = 1'b0;
    @(posedge clk);

    while (frames < NFRAMES && cyc < 30000) begin
      @(negedge clk);
      cyc++;

      // Apply a mid-frame reset from last cycle: everything is abandoned.
      if (rst_mid) begin
        act = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0;
        q0.delete(); q1.delete(); pop0 = 1'b0; pop1 = 1'b0;
        last = 1; rst_mid = 1'b0; post_rst = 1'b1;
      end
      // FIFO pops caused by last cycle's rd_en
      if (pop0 && q0.size() > 0) void'(q0.pop_front());
      if (pop1 && q1.size() > 0) void'(q1.pop_front());

      // Expected registered outputs for this cycle
      eg = 2'b00; er = 2'b00; ed = 2'b00; ee = 1'b0; eb = 1'b0; ei = 1'b0; edin = 8'h00;
      k = 0;
      if (act) begin
        k  = cyc - s;
        oh = (g == 1) ? 2'b10 : 2'b01;
        if (k == dk) begin
          ed = oh; ee = err_m;
        end else begin
          eg = oh; eb = 1'b1;
          if (L > 0) begin
            if (k == 1) ei = 1'b1;
            if (k >= SHR + 2 && k <= SHR + 1 + L) begin
              er   = oh;
              edin = fb[k - SHR - 2];
              ei   = (k == SHR + 1 + L);
            end
          end
        end
      end
      check("ctl", 32'({bus_if.grant, bus_if.rd_en, bus_if.done, bus_if.err, bus_if.busy, bus_if.fr_indicator}),
            32'({eg, er, ed, ee, eb, ei}));
      pop0 = bus_if.rd_en[0];
      pop1 = bus_if.rd_en[1];

      // Frame completion: requester may keep req high with a fresh frame.
      if (act && k == dk) begin
        act = 1'b0; done_cyc = cyc; last = g; frames++;
        pend[g] = 1'b0;
        if (g == 0) q0.delete(); else q1.delete();
        if (!directed && $urandom_range(0, 1) == 1) mkframe(g, rndlen());
        directed = 1'b0;
      end

      // Reset: at start-up, and twice in the middle of a DATA phase.
      rst_now = (cyc < 3);
      if (act && L >= 2 && k == SHR + 2 + L / 2 &&
          ((resets == 0 && frames >= 5) || (resets == 1 && frames >= 15))) begin
        rst_now = 1'b1; rst_mid = 1'b1; resets++;
      end
      reset_n = rst_now ? 1'b0 : 1'b1;

      // New frames from the requesters
      if (!rst_now) begin
        if (post_rst) begin
          mkframe(0, rndlen()); mkframe(1, rndlen()); post_rst = 1'b0;
        end else if (directed) begin
          if (cyc == 5) begin
            pend[0] = 1'b1; plen[0] = 3;
            q0.push_back(8'hA1); q0.push_back(8'hA2); q0.push_back(8'hA3);
          end
        end else begin
          for (int i = 0; i < 2; i++)
            if (!pend[i] && $urandom_range(0, 7) == 0) mkframe(i, rndlen());
        end
      end

      // Drive requester and framer-side inputs
      bus_if.req  = {pend[1], pend[0]};
      bus_if.len0 = pend[0] ? LEN_W'(plen[0]) : LEN_W'($urandom);
      bus_if.len1 = pend[1] ? LEN_W'(plen[1]) : LEN_W'($urandom);
      bus_if.data0 = (q0.size() > 0) ? q0[0] : 8'($urandom);
      bus_if.data1 = (q1.size() > 0) ? q1[0] : 8'($urandom);
      nxt = ($urandom_range(0, 3) == 0);
      if (act && L > 0) begin
        fcs0 = SHR + 2 + L;
        if (k == 1) nxt = 1'b1;               // framer pulse during START must be ignored
        else if (k >= fcs0) nxt = (k == fcs0 + j);
      end
      bus_if.fr_next_indicator = nxt;

      // Arbitration decision made at the end of this cycle
      if (!rst_now && !act && cyc != done_cyc && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) w = (last == 0) ? 1 : 0;
        else                    w = pend[1] ? 1 : 0;
        act = 1'b1; s = cyc; g = w; L = plen[w];
        fb = (w == 1) ? q1 : q0;
        r = int'($urandom_range(0, 9));
        if (directed || r < 7) j = FCS - 1;
        else if (r < 9)        j = int'($urandom_range(0, FCS + MARGIN - 1));
        else                   j = -1;
        if (L == 0)      dk = 2;
        else if (j >= 0) dk = SHR + 3 + L + j;
        else             dk = SHR + 2 + L + FCS + MARGIN;
        err_m = (L == 0) || (j < 0);
      end

      #1;
      check("din", 32'(bus_if.fr_din), 32'(edin));
    end

    check("frames_done", 32'(frames), 32'(NFRAMES));
    check("mid_resets", 32'(resets), 32'(2));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
